// File: rtl/trace_pkg.sv
// Shared definitions for the chromosome trace memory: reader state encoding
// and the byte layout of one 32-bit trace word (also used by the writer).
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_CHECK = 3'd4
  } trace_state_e;

  localparam int TRACE_WORD_BYTES = 4;

  // Trace word layout: {input, 4'b0 + index, expected, output}
  localparam int FIELD_INPUT_MSB    = 31;
  localparam int FIELD_INPUT_LSB    = 24;
  localparam int FIELD_INDEX_MSB    = 23;
  localparam int FIELD_INDEX_LSB    = 16;
  localparam int FIELD_EXPECTED_MSB = 15;
  localparam int FIELD_EXPECTED_LSB = 8;
  localparam int FIELD_OUTPUT_MSB   = 7;
  localparam int FIELD_OUTPUT_LSB   = 0;

endpackage

// File: rtl/trace_word_serializer.sv
// Turns one loaded 32-bit trace word into four MSB-first bytes on a
// valid/ready byte interface.
module trace_word_serializer
  import trace_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        byte_ready_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        byte_fire_o,
  output logic        last_fire_o
);

  // Handshake: a byte transfers on any rising edge where byte_valid_o and
  // byte_ready_i are both high; byte_o is held unchanged until that edge.
  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        last_byte;

  assign last_byte    = (idx_q == 2'(TRACE_WORD_BYTES - 1));
  assign byte_o       = shift_q[FIELD_INPUT_MSB:FIELD_INPUT_LSB];
  assign byte_valid_o = valid_q;
  assign byte_fire_o  = valid_q & byte_ready_i;
  assign last_fire_o  = byte_fire_o & last_byte;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (byte_fire_o) begin
      shift_d = {shift_q[23:0], 8'h00};
      idx_d   = idx_q + 2'd1;
      if (last_byte) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/trace_memory_reader.sv
// Reads trace words 0..N-1 and streams them out as bytes to the host link.
// Define TRACE_READER_CHECKSUM_EN to append an 8-bit running-sum byte.
module trace_memory_reader
  import trace_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStartRead,
  input  logic [ADDR_WIDTH-1:0] iWordCount,
  input  logic                  iDoneAck,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  input  logic [DATA_WIDTH-1:0] iMemQ,
  output logic [7:0]            oByte,
  output logic                  oByteValid,
  input  logic                  iByteReady,
  output logic                  oReadyToRead,
  output logic                  oDone,
  output logic [2:0]            oState
);

  if (DATA_WIDTH != 8 * TRACE_WORD_BYTES) begin : g_bad_width
    $error("trace_memory_reader: DATA_WIDTH must be 32");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("trace_memory_reader: MEM_LATENCY must be 1..4");
  end

  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

`ifdef TRACE_READER_CHECKSUM_EN
  localparam trace_state_e END_STATE = ST_CHECK;
`else
  localparam trace_state_e END_STATE = ST_DONE;
`endif

  trace_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [2:0]            lat_q, lat_d;
  logic                  ser_load;
  logic [7:0]            ser_byte;
  logic                  ser_valid;
  logic                  ser_fire;
  logic                  ser_last_fire;

`ifdef TRACE_READER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign addr_inc = addr_q + 1'b1;

  trace_word_serializer u_serializer (
    .clk_i        (iClock),
    .rst_i        (iReset),
    .load_i       (ser_load),
    .word_i       (iMemQ),
    .byte_ready_i (iByteReady),
    .byte_o       (ser_byte),
    .byte_valid_o (ser_valid),
    .byte_fire_o  (ser_fire),
    .last_fire_o  (ser_last_fire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    lat_d    = lat_q;
    ser_load = 1'b0;
`ifdef TRACE_READER_CHECKSUM_EN
    sum_d = sum_q;
    if (ser_fire) sum_d = sum_q + ser_byte;
`endif
    case (state_q)
      ST_IDLE: begin
        if (iStartRead) begin
          count_d = iWordCount;
          addr_d  = '0;
          lat_d   = '0;
`ifdef TRACE_READER_CHECKSUM_EN
          sum_d = '0;
`endif
          // A zero count means no words at all, never 2^ADDR_WIDTH.
          state_d = (iWordCount == '0) ? END_STATE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (lat_q == LAT_LAST) begin
          ser_load = 1'b1;
          lat_d    = '0;
          state_d  = ST_SEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_SEND: begin
        if (ser_last_fire) begin
          if (addr_inc == count_q) begin
            state_d = END_STATE;
          end else begin
            addr_d  = addr_inc;
            state_d = ST_FETCH;
          end
        end
      end
`ifdef TRACE_READER_CHECKSUM_EN
      ST_CHECK: begin
        if (iByteReady) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (iDoneAck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      lat_q   <= '0;
`ifdef TRACE_READER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      lat_q   <= lat_d;
`ifdef TRACE_READER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

`ifdef TRACE_READER_CHECKSUM_EN
  assign oByte      = (state_q == ST_CHECK) ? sum_q : ser_byte;
  assign oByteValid = ser_valid | (state_q == ST_CHECK);
`else
  assign oByte      = ser_byte;
  assign oByteValid = ser_valid;
`endif

  assign oMemAddress  = addr_q;
  assign oReadyToRead = (state_q == ST_IDLE);
  assign oDone        = (state_q == ST_DONE);
  assign oState       = state_q;

endmodule

// File: tb/tb_trace_memory_reader.sv
// Directed bench for trace_memory_reader. Memory latency is taken from
// the LAT parameter (default 2).
module tb_trace_memory_reader #(
  parameter int LAT = 2
);

`ifdef TRACE_READER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        iReset = 1'b1;
  logic        iStartRead = 1'b0;
  logic [15:0] iWordCount = '0;
  logic        iDoneAck = 1'b0;
  logic [15:0] oMemAddress;
  logic [31:0] iMemQ;
  logic [7:0]  oByte;
  logic        oByteValid;
  logic        iByteReady = 1'b1;
  logic        oReadyToRead;
  logic        oDone;
  logic [2:0]  oState;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Address changes on edge E; data is valid for sampling at edge E+LAT.
  logic [31:0] mem [0:15];
  logic [31:0] pipe [0:3];
  always @(posedge clk) begin
    pipe[0] <= mem[oMemAddress[3:0]];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  if (LAT == 1) begin : g_lat1
    assign iMemQ = mem[oMemAddress[3:0]];
  end else begin : g_latn
    assign iMemQ = pipe[LAT-2];
  end

  trace_memory_reader #(.ADDR_WIDTH(16), .MEM_LATENCY(LAT), .DATA_WIDTH(32)) dut (
    .iClock       (clk),
    .iReset       (iReset),
    .iStartRead   (iStartRead),
    .iWordCount   (iWordCount),
    .iDoneAck     (iDoneAck),
    .oMemAddress  (oMemAddress),
    .iMemQ        (iMemQ),
    .oByte        (oByte),
    .oByteValid   (oByteValid),
    .iByteReady   (iByteReady),
    .oReadyToRead (oReadyToRead),
    .oDone        (oDone),
    .oState       (oState)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] addr_q[$];
  int          done_seen;
  int          cycles;
  int          stall_err;

  // ---------------- driver tasks ----------------
  task automatic start_read(input logic [15:0] n);
    @(negedge clk);
    iStartRead = 1'b1;
    iWordCount = n;
    iByteReady = 1'b1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    iDoneAck = 1'b1;
    @(negedge clk);
    iDoneAck = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  // poke_at: iteration at which a stray start with count 5 is pulsed.
  task automatic collect(input int mode, input int poke_at);
    int cyc;
    int ph;
    logic prev_stalled;
    logic [7:0] prev_byte;
    logic rdy;
    got_q.delete();
    addr_q.delete();
    done_seen = 0;
    stall_err = 0;
    cyc = 0;
    ph = 0;
    prev_stalled = 1'b0;
    prev_byte = '0;
    while (cyc < 200) begin
      @(negedge clk);
      iStartRead = 1'b0;
      if (oDone) begin
        done_seen = 1;
        break;
      end
      if (prev_stalled && (!oByteValid || oByte !== prev_byte)) stall_err++;
      rdy = (mode == 0) ? 1'b1 : ((ph % 3) == 0);
      ph++;
      iByteReady = rdy;
      if (cyc + 1 == poke_at) begin
        iStartRead = 1'b1;
        iWordCount = 16'd5;
      end
      if (oByteValid && rdy) begin
        got_q.push_back(oByte);
        addr_q.push_back(oMemAddress);
      end
      prev_stalled = oByteValid && !rdy;
      prev_byte = oByte;
      cyc++;
    end
    cycles = cyc;
    iStartRead = 1'b0;
    iByteReady = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iReset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", oState); end
    checks++; if (oMemAddress !== 16'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", oMemAddress); end
    checks++; if (oByte !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h exp=00", oByte); end
    checks++; if (oByteValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", oByteValid); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", oDone); end
    checks++; if (oReadyToRead !== 1'b1) begin errors++; $display("FAIL reset_rtr got=%b exp=1", oReadyToRead); end
    iReset = 1'b0;
  endtask

  task automatic test_basic();
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    if (CK == 1) exp_q.push_back(8'h64);
    start_read(16'd2);
    collect(0, -1);
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_seen); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (cycles !== 2 * (LAT + 4) + CK) begin errors++; $display("FAIL basic_cycles got=%0d exp=%0d", cycles, 2 * (LAT + 4) + CK); end
    do_ack();
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL basic_ack_state got=%0d exp=0", oState); end
    checks++; if (oReadyToRead !== 1'b1) begin errors++; $display("FAIL basic_ack_rtr got=%b exp=1", oReadyToRead); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL basic_ack_done got=%b exp=0", oDone); end
  endtask

  task automatic test_backpressure();
    mem[0] = 32'hDEADBEEF;
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CK == 1) exp_q.push_back(8'h38);
    start_read(16'd1);
    collect(1, -1);
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", done_seen); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    do_ack();
  endtask

  task automatic test_zero_count();
    exp_q.delete();
    if (CK == 1) exp_q.push_back(8'h00);
    start_read(16'd0);
    collect(0, -1);
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL zero_done got=%0d exp=1", done_seen); end
    checks++; if (cycles !== CK) begin errors++; $display("FAIL zero_cycles got=%0d exp=%0d", cycles, CK); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL zero_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    if (CK == 1 && got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL zero_sum got=%h exp=00", got_q[0]); end
    end
    // start while in DONE must be ignored
    @(negedge clk);
    iStartRead = 1'b1;
    iWordCount = 16'd3;
    @(negedge clk);
    iStartRead = 1'b0;
    checks++; if (oState !== 3'd3) begin errors++; $display("FAIL done_start_ignored got=%0d exp=3", oState); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    mem[0] = 32'hA0A1A2A3;
    mem[1] = 32'hB0B1B2B3;
    mem[2] = 32'hC0C1C2C3;
    start_read(16'd3);
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      iStartRead = 1'b0;
      if (oByteValid) n++;
      cyc++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL mid_progress got=%0d exp=6", n); end
    @(negedge clk);
    checks++; if (oByteValid !== 1'b1 || oByte !== 8'hB2) begin errors++; $display("FAIL mid_pending got=%b/%h exp=1/b2", oByteValid, oByte); end
    iReset = 1'b1;
    iByteReady = 1'b0;
    @(negedge clk);
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL mid_rst_state got=%0d exp=0", oState); end
    checks++; if (oByteValid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", oByteValid); end
    checks++; if (oByte !== 8'h00) begin errors++; $display("FAIL mid_rst_byte got=%h exp=00", oByte); end
    checks++; if (oMemAddress !== 16'd0) begin errors++; $display("FAIL mid_rst_addr got=%h exp=0", oMemAddress); end
    iReset = 1'b0;
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    if (CK == 1) exp_q.push_back(8'h86);
    start_read(16'd1);
    collect(0, -1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_restart_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_restart_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    do_ack();
  endtask

  task automatic test_start_ignored();
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    start_read(16'd2);
    collect(0, 4);
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL ign_done got=%0d exp=1", done_seen); end
    checks++; if (got_q.size() !== 8 + CK) begin errors++; $display("FAIL ign_len got=%0d exp=%0d", got_q.size(), 8 + CK); end
    do_ack();
    checks++; if (oReadyToRead !== 1'b1) begin errors++; $display("FAIL ign_rtr got=%b exp=1", oReadyToRead); end
  endtask

  task automatic test_latency();
    mem[0] = 32'h01020304;
    mem[1] = 32'h05060708;
    mem[2] = 32'h090A0B0C;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    if (CK == 1) exp_q.push_back(8'h4E);
    start_read(16'd3);
    collect(0, -1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL lat_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL lat_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    for (int i = 0; i < 12 && i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== 16'(i / 4)) begin errors++; $display("FAIL lat_addr[%0d] got=%0d exp=%0d", i, addr_q[i], i / 4); end
    end
    checks++; if (cycles !== 3 * (LAT + 4) + CK) begin errors++; $display("FAIL lat_cycles got=%0d exp=%0d", cycles, 3 * (LAT + 4) + CK); end
    do_ack();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_0000 | i;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_start_ignored();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
